mips32_muldiv: RTL and testbench

MIPS32_MULDIV -- requirements
Module: mips32_muldiv

---
 rtl/mips32_muldiv.sv | 137 +++++++++++++
 tb/tb_mips32_muldiv.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mips32_muldiv.sv
// Iterative MIPS-style multiply/divide unit: one radix-2 step per cycle,
// sign handling on magnitudes with a single correction cycle before results land in HI/LO.
`timescale 1ns/1ps
module mips32_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t           state, state_next;
   logic [CW-1:0]    count;
   logic             is_div, neg_lo, neg_hi;
   logic [WIDTH-1:0] opnd_b, work_hi, work_lo;

   logic             a_neg, b_neg, b_zero;
   logic [WIDTH-1:0] a_abs, b_abs;
   logic [WIDTH:0]   mul_sum, div_shift, div_diff;
   logic             div_ok;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0] fix_hi, fix_lo;

   // Operand magnitudes; op[0] selects signed interpretation, op[1] selects divide.
   always_comb begin
      a_neg  = op[0] & A[WIDTH-1];
      b_neg  = op[0] & B[WIDTH-1];
      a_abs  = a_neg ? (~A + 1'b1) : A;
      b_abs  = b_neg ? (~B + 1'b1) : B;
      b_zero = (B == '0);
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE: begin
            if (start)
               state_next = (op[1] && b_zero) ? DONE : RUN;
            else
               state_next = IDLE;
         end
         RUN:     if (count == CW'(1)) state_next = FIX;
         FIX:     state_next = DONE;
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state == RUN) || (state == FIX);
   assign done = (state == DONE);

   // work_hi is the product accumulator or the partial remainder; work_lo holds
   // the multiplier (shifted out) or the dividend (shifted out, quotient shifted in).
   always_comb begin
      mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd_b} : {(WIDTH+1){1'b0}});
      div_shift = {work_hi, work_lo[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd_b};
      div_ok    = ~div_diff[WIDTH];
   end

   always_comb begin
      prod     = {work_hi, work_lo};
      prod_fix = neg_lo ? (~prod + 1'b1) : prod;
      if (is_div) begin
         fix_hi = neg_hi ? (~work_hi + 1'b1) : work_hi;
         fix_lo = neg_lo ? (~work_lo + 1'b1) : work_lo;
      end else begin
         fix_hi = prod_fix[2*WIDTH-1:WIDTH];
         fix_lo = prod_fix[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         count    <= '0;
         opnd_b   <= '0;
         work_hi  <= '0;
         work_lo  <= '0;
         is_div   <= 1'b0;
         neg_lo   <= 1'b0;
         neg_hi   <= 1'b0;
         HI       <= '0;
         LO       <= '0;
         div_zero <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  count   <= CW'(WIDTH);
                  opnd_b  <= b_abs;
                  work_hi <= '0;
                  work_lo <= a_abs;
                  is_div  <= op[1];
                  neg_lo  <= a_neg ^ b_neg;
                  neg_hi  <= a_neg;
                  // A zero divisor skips the datapath and reports immediately.
                  if (op[1] && b_zero) begin
                     HI       <= A;
                     LO       <= '1;
                     div_zero <= 1'b1;
                  end
               end
            end
            RUN: begin
               count <= count - 1'b1;
               if (is_div) begin
                  work_hi <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                  work_lo <= {work_lo[WIDTH-2:0], div_ok};
               end else begin
                  work_hi <= mul_sum[WIDTH:1];
                  work_lo <= {mul_sum[0], work_lo[WIDTH-1:1]};
               end
            end
            FIX: begin
               HI       <= fix_hi;
               LO       <= fix_lo;
               div_zero <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mips32_muldiv.sv
// Randomized self-checking bench for mips32_muldiv against a plain-arithmetic reference.
`timescale 1ns/1ps
module tb_mips32_muldiv;

   logic        clk, rst, start;
   logic [1:0]  op_i;
   logic [31:0] a_i, b_i;
   logic        busy, done, div_zero;
   logic [31:0] HI, LO;

   int          nCompared, nMismatched;
   logic [31:0] expHi, expLo;
   logic        expDz;

   mips32_muldiv #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op_i), .A(a_i), .B(b_i),
      .busy(busy), .done(done), .HI(HI), .LO(LO), .div_zero(div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nCompared++;
      if (obs !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Reference results straight from integer arithmetic.
   function automatic void refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo, output logic dz);
      longint      sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      dz = 1'b0;
      hi = '0;
      lo = '0;
      if (op[1] && b == 32'd0) begin
         hi = a;
         lo = 32'hFFFF_FFFF;
         dz = 1'b1;
      end else begin
         case (op)
            2'b00: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
            2'b01: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
            2'b10: begin lo = a / b; hi = a % b; end
            default: begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
         endcase
      end
   endfunction

   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                input bit chained, input bit noisy);
      logic [31:0] eh, el;
      logic        ed;
      int          lat, edges;
      refModel(op, a, b, eh, el, ed);
      lat = (op[1] && b == 32'd0) ? 0 : 33;
      if (!chained) @(negedge clk);
      start = 1'b1; op_i = op; a_i = a; b_i = b;
      @(posedge clk); #1;
      edges = 0;
      while (!done && edges < 40) begin
         checkOutput("busy_run", 64'(busy), 64'd1);
         if (edges == 16) begin
            checkOutput("hi_hold", 64'(HI), 64'(expHi));
            checkOutput("lo_hold", 64'(LO), 64'(expLo));
         end
         if (noisy) begin
            start = 1'($urandom_range(0, 1));
            op_i  = 2'($urandom);
            a_i   = $urandom;
            b_i   = $urandom;
         end else
            start = 1'b0;
         @(posedge clk); #1;
         edges++;
      end
      start = 1'b0;
      checkOutput("latency", 64'(edges), 64'(lat));
      checkOutput("done", 64'(done), 64'd1);
      checkOutput("busy_done", 64'(busy), 64'd0);
      checkOutput("HI", 64'(HI), 64'(eh));
      checkOutput("LO", 64'(LO), 64'(el));
      checkOutput("div_zero", 64'(div_zero), 64'(ed));
      expHi = eh; expLo = el; expDz = ed;
   endtask

   // One edge with start low: done must drop and results must hold.
   task automatic idleCheck();
      @(posedge clk); #1;
      checkOutput("done_pulse", 64'(done), 64'd0);
      checkOutput("busy_idle", 64'(busy), 64'd0);
      checkOutput("HI_idle", 64'(HI), 64'(expHi));
      checkOutput("LO_idle", 64'(LO), 64'(expLo));
      checkOutput("dz_idle", 64'(div_zero), 64'(expDz));
   endtask

   task automatic checkReset();
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_HI", 64'(HI), 64'd0);
      checkOutput("rst_LO", 64'(LO), 64'd0);
      checkOutput("rst_dz", 64'(div_zero), 64'd0);
      expHi = '0; expLo = '0; expDz = 1'b0;
   endtask

   logic [31:0] specials [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

   initial begin
      logic [31:0] ra, rb;
      int          sawDone;
      nCompared = 0; nMismatched = 0;
      rst = 1'b1; start = 1'b0; op_i = '0; a_i = '0; b_i = '0;
      #1;
      checkReset();
      @(negedge clk); rst = 1'b0;

      // Directed cases; the first is issued for the very first edge after reset.
      applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
      idleCheck();
      applyStimulus(2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 0, 0);
      applyStimulus(2'b01, 32'h0000_0007, 32'h0000_0006, 1, 0);
      idleCheck();
      applyStimulus(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 0, 1);
      applyStimulus(2'b10, 32'h0000_0064, 32'h0000_0007, 0, 0);
      applyStimulus(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
      idleCheck();
      applyStimulus(2'b10, 32'h1234_5678, 32'h0000_0000, 0, 0);
      idleCheck();
      applyStimulus(2'b11, 32'h8765_4321, 32'h0000_0000, 0, 0);
      applyStimulus(2'b00, 32'h0000_0003, 32'h0000_0005, 1, 0);
      idleCheck();

      for (int i = 0; i < 24; i++) begin
         ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
         rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
         if ($urandom_range(0, 5) == 0) rb = 32'h0;
         if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(8, 28);
         applyStimulus(2'($urandom), ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 2) == 0) idleCheck();
      end

      // Reset in the middle of a multiply while start is being toggled.
      @(negedge clk);
      start = 1'b1; op_i = 2'b00; a_i = $urandom; b_i = $urandom;
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) begin
         start = 1'($urandom_range(0, 1));
         a_i = $urandom;
         @(posedge clk); #1;
      end
      start = 1'b0;
      #2; rst = 1'b1; #1;
      checkReset();
      @(posedge clk); @(negedge clk); rst = 1'b0;
      sawDone = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done) sawDone++;
      end
      checkOutput("no_done_after_rst", 64'(sawDone), 64'd0);
      checkOutput("HI_after_rst", 64'(HI), 64'd0);
      checkOutput("LO_after_rst", 64'(LO), 64'd0);

      // Start presented as reset falls must be taken on the next edge.
      @(negedge clk); rst = 1'b1; #1; rst = 1'b0;
      applyStimulus(2'b01, 32'hFFFF_FF00, 32'h0000_0100, 1, 0);
      idleCheck();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
